// File: rtl/serial_frame_rx_if.sv
// Serial receive link bundle: bit input side plus parallel word/status outputs.
interface serial_frame_rx_if #(
  parameter int DATA_W = 8
);
  logic              din;
  logic              din_en;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              sync_found;
  logic              busy;
  logic              parity_err;

  modport master (
    output din, din_en,
    input  data_out, data_valid, sync_found, busy, parity_err
  );

  modport slave (
    input  din, din_en,
    output data_out, data_valid, sync_found, busy, parity_err
  );
endinterface

// File: rtl/serial_frame_rx.sv
// Sync-word hunting serial deserializer producing WORDS MSB-first payload words per frame.
// Optional per-word even parity bit enabled by defining SERIAL_FRAME_RX_PARITY_EN.
module serial_frame_rx #(
  parameter int              SYNC_W   = 8,
  parameter logic [SYNC_W-1:0] SYNC_PAT = 8'hA5,
  parameter int              DATA_W   = 8,
  parameter int              WORDS    = 2
) (
  input logic          clk,
  input logic          rst,
  serial_frame_rx_if.slave bus
);

  localparam int FILL_W = $clog2(SYNC_W + 1);
  localparam int BC_W   = $clog2(DATA_W);
  localparam int WC_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
`ifdef SERIAL_FRAME_RX_PARITY_EN
  localparam int WSR_W  = DATA_W;
`else
  localparam int WSR_W  = DATA_W - 1;
`endif

  typedef enum logic [1:0] {
    S_HUNT,
    S_DATA
`ifdef SERIAL_FRAME_RX_PARITY_EN
    , S_PAR
`endif
  } state_t;

  // Only the history bits are kept; the window is completed by the incoming bit.
  state_t              r_state,     w_state_nx;
  logic [SYNC_W-2:0]   r_hunt_sr,   w_hunt_nx;
  logic [FILL_W-1:0]   r_fill,      w_fill_nx;
  logic [WSR_W-1:0]    r_word_sr,   w_word_nx;
  logic [BC_W-1:0]     r_bit_cnt,   w_bit_nx;
  logic [WC_W-1:0]     r_word_cnt,  w_wcnt_nx;
  logic [DATA_W-1:0]   r_data_out,  w_dout_nx;
  logic                r_data_valid, w_dv_nx;
  logic                r_sync_found, w_sf_nx;
  logic                r_busy;
  logic [SYNC_W-1:0]   w_hunt_win;
  logic [DATA_W-1:0]   w_word_win;
  logic                w_word_done;
`ifdef SERIAL_FRAME_RX_PARITY_EN
  logic                r_parity_err, w_perr_nx;
`endif

  always_comb begin
    w_state_nx  = r_state;
    w_hunt_nx   = r_hunt_sr;
    w_fill_nx   = r_fill;
    w_word_nx   = r_word_sr;
    w_bit_nx    = r_bit_cnt;
    w_wcnt_nx   = r_word_cnt;
    w_dout_nx   = r_data_out;
    w_dv_nx     = 1'b0;
    w_sf_nx     = 1'b0;
    w_word_done = 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    w_perr_nx   = 1'b0;
`endif
    w_hunt_win  = {r_hunt_sr, bus.din};
    w_word_win  = {r_word_sr[DATA_W-2:0], bus.din};

    if (bus.din_en) begin
      case (r_state)
        S_HUNT: begin
          w_hunt_nx = w_hunt_win[SYNC_W-2:0];
          if (r_fill != FILL_W'(SYNC_W))
            w_fill_nx = r_fill + FILL_W'(1);
          // Fill qualification keeps reset/entry zeros from matching an all-zero pattern.
          if (w_fill_nx == FILL_W'(SYNC_W) && w_hunt_win == SYNC_PAT) begin
            w_sf_nx    = 1'b1;
            w_state_nx = S_DATA;
            w_bit_nx   = '0;
            w_wcnt_nx  = '0;
          end
        end
        S_DATA: begin
          w_word_nx = w_word_win[WSR_W-1:0];
          if (r_bit_cnt == BC_W'(DATA_W - 1)) begin
            w_bit_nx = '0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            w_state_nx = S_PAR;
`else
            w_dout_nx   = w_word_win;
            w_dv_nx     = 1'b1;
            w_word_done = 1'b1;
`endif
          end else begin
            w_bit_nx = r_bit_cnt + BC_W'(1);
          end
        end
`ifdef SERIAL_FRAME_RX_PARITY_EN
        S_PAR: begin
          w_dout_nx   = r_word_sr;
          w_dv_nx     = 1'b1;
          w_perr_nx   = ^{r_word_sr, bus.din};
          w_word_done = 1'b1;
          w_state_nx  = S_DATA;
        end
`endif
        default: w_state_nx = S_HUNT;
      endcase

      // Last word of the frame: restart hunting with a clean window on the next bit.
      if (w_word_done) begin
        if (r_word_cnt == WC_W'(WORDS - 1)) begin
          w_state_nx = S_HUNT;
          w_hunt_nx  = '0;
          w_fill_nx  = '0;
          w_wcnt_nx  = '0;
        end else begin
          w_wcnt_nx = r_word_cnt + WC_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_HUNT;
      r_hunt_sr    <= '0;
      r_fill       <= '0;
      r_word_sr    <= '0;
      r_bit_cnt    <= '0;
      r_word_cnt   <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_sync_found <= 1'b0;
      r_busy       <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nx;
      r_hunt_sr    <= w_hunt_nx;
      r_fill       <= w_fill_nx;
      r_word_sr    <= w_word_nx;
      r_bit_cnt    <= w_bit_nx;
      r_word_cnt   <= w_wcnt_nx;
      r_data_out   <= w_dout_nx;
      r_data_valid <= w_dv_nx;
      r_sync_found <= w_sf_nx;
      r_busy       <= (w_state_nx != S_HUNT);
`ifdef SERIAL_FRAME_RX_PARITY_EN
      r_parity_err <= w_perr_nx;
`endif
    end
  end

  assign bus.data_out   = r_data_out;
  assign bus.data_valid = r_data_valid;
  assign bus.sync_found = r_sync_found;
  assign bus.busy       = r_busy;
`ifdef SERIAL_FRAME_RX_PARITY_EN
  assign bus.parity_err = r_parity_err;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx: directed frames push expected events, a monitor pops them.
module tb_serial_frame_rx;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  serial_frame_rx_if #(.DATA_W(DATA_W)) bus ();

  serial_frame_rx #(
    .SYNC_W(8), .SYNC_PAT(8'hA5), .DATA_W(DATA_W), .WORDS(2)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {E_SYNC, E_WORD, E_BRISE, E_BFALL, E_ZERO} ekind_t;
  typedef struct {
    ekind_t     kind;
    int         cyc;
    logic [7:0] data;
    logic       perr;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   last_edge = 0;
  bit   mon_en = 1'b0;
  bit   gap_mode = 1'b0;
  logic prev_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input ekind_t k, input int c, input logic [7:0] d, input logic p);
    exp_t e;
    e.kind = k; e.cyc = c; e.data = d; e.perr = p;
    q.push_back(e);
  endtask

  // Output events seen by the monitor must match the queue front exactly in kind and cycle.
  task automatic expect_ev(input ekind_t k);
    exp_t e;
    n_chk++;
    if (q.size() == 0 || q[0].kind != k || q[0].cyc != cyc) begin
      n_fail++;
      $display("FAIL unexpected_%s cyc=%0d: got event, want %s", k.name(), cyc,
               (q.size() == 0) ? "none" : $sformatf("%s@%0d", q[0].kind.name(), q[0].cyc));
    end else begin
      e = q.pop_front();
      if (k == E_WORD) begin
        check("data_out", {24'd0, bus.data_out}, {24'd0, e.data});
        check("parity_err", {31'd0, bus.parity_err}, {31'd0, e.perr});
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL missing_%s: got nothing at cyc=%0d, want event", q[0].kind.name(), q[0].cyc);
        void'(q.pop_front());
      end
      if (bus.sync_found) expect_ev(E_SYNC);
      if (bus.data_valid) expect_ev(E_WORD);
      if (bus.busy !== prev_busy) expect_ev(bus.busy ? E_BRISE : E_BFALL);
      prev_busy = bus.busy;
      if (q.size() > 0 && q[0].kind == E_ZERO && q[0].cyc == cyc) begin
        void'(q.pop_front());
        check("zero_data_out", {24'd0, bus.data_out}, 32'd0);
        check("zero_data_valid", {31'd0, bus.data_valid}, 32'd0);
        check("zero_sync_found", {31'd0, bus.sync_found}, 32'd0);
        check("zero_busy", {31'd0, bus.busy}, 32'd0);
        check("zero_parity_err", {31'd0, bus.parity_err}, 32'd0);
      end
    end
  end

  task automatic drive(input logic b, input logic en);
    @(posedge clk);
    #1;
    bus.din    = b;
    bus.din_en = en;
    if (en) last_edge = cyc + 1;
  endtask

  task automatic tx(input logic [7:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      if (gap_mode) drive(1'($urandom_range(0, 1)), 1'b0);
      drive(v[i], 1'b1);
    end
  endtask

  task automatic tx_word(input logic [7:0] v, input logic pbit);
    tx(v, 8);
`ifdef SERIAL_FRAME_RX_PARITY_EN
    tx({7'd0, pbit}, 1);
`endif
  endtask

  task automatic sync_hdr();
    tx(8'hA5, 8);
    push(E_SYNC, last_edge, 8'h00, 1'b0);
    push(E_BRISE, last_edge, 8'h00, 1'b0);
  endtask

  task automatic frame(input logic [7:0] w0, input logic [7:0] w1);
    sync_hdr();
    tx_word(w0, ^w0);
    push(E_WORD, last_edge, w0, 1'b0);
    tx_word(w1, ^w1);
    push(E_WORD, last_edge, w1, 1'b0);
    push(E_BFALL, last_edge, 8'h00, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  int rst_edge;

  initial begin
    bus.din    = 1'b0;
    bus.din_en = 1'b0;
    rst        = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    push(E_ZERO, cyc, 8'h00, 1'b0);

    // Basic frame, then noisy prefix back-to-back with no idle bit
    frame(8'h3C, 8'hF0);
    tx(8'h0D, 4);
    frame(8'h12, 8'h34);

    // Same frame with din_en toggling
    gap_mode = 1'b1;
    frame(8'h3C, 8'hF0);
    gap_mode = 1'b0;

    // Abort mid-payload with reset; din held active to exercise reset priority
    sync_hdr();
    tx(8'h03, 4);
    @(posedge clk);
    #1;
    rst        = 1'b1;
    bus.din    = 1'b1;
    bus.din_en = 1'b1;
    rst_edge   = cyc + 1;
    push(E_BFALL, rst_edge, 8'h00, 1'b0);
    push(E_ZERO, rst_edge, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    bus.din_en = 1'b0;
    frame(8'h3C, 8'hF0);

    // Sync pattern inside payload is plain data
    frame(8'hA5, 8'h5A);

`ifdef SERIAL_FRAME_RX_PARITY_EN
    sync_hdr();
    tx_word(8'h3C, 1'b0);
    push(E_WORD, last_edge, 8'h3C, 1'b0);
    tx_word(8'h01, 1'b0);
    push(E_WORD, last_edge, 8'h01, 1'b1);
    push(E_BFALL, last_edge, 8'h00, 1'b0);
`endif

    drive(1'b0, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1;
    while (q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL leftover_%s: got nothing at cyc=%0d, want event", q[0].kind.name(), q[0].cyc);
      void'(q.pop_front());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
